// File: rtl/shared_adder_arbiter.sv
// shared_adder_arbiter: round-robin arbiter that time-shares one ripple-carry adder among NUM_REQ requesters
module shared_adder_arbiter #(
    parameter  int DATA_WIDTH = 8,
    parameter  int NUM_REQ    = 4,
    localparam int ID_W       = ($clog2(NUM_REQ) > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_a,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_b,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          res_valid,
    input  logic                          res_ready,
    output logic [DATA_WIDTH:0]           res_sum,
    output logic [ID_W-1:0]               res_id
);
    logic [ID_W-1:0]       r_prio;
    logic                  r_valid;
    logic [DATA_WIDTH:0]   r_sum;
    logic [ID_W-1:0]       r_id;
    logic [ID_W-1:0]       w_win;
    logic                  w_found;
    logic                  w_can;
    logic                  w_xfer;
    logic [DATA_WIDTH-1:0] w_a;
    logic [DATA_WIDTH-1:0] w_b;
    logic [DATA_WIDTH-1:0] w_s;
    logic [DATA_WIDTH:0]   w_carry;
    int                    w_dist;
    int                    w_best;
    // pick the valid requester closest to prio in rotating order, then steer its operands to the adder
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_best  = NUM_REQ;
        w_dist  = 0;
        w_a     = '0;
        w_b     = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_dist = (i + NUM_REQ - int'(r_prio)) % NUM_REQ;
            if (req_valid[i] && w_dist < w_best) begin
                w_best  = w_dist;
                w_found = 1'b1;
                w_win   = ID_W'(i);
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_win == ID_W'(i)) begin
                w_a = req_a[i*DATA_WIDTH +: DATA_WIDTH];
                w_b = req_b[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end
    assign w_carry[0] = 1'b0;
    for (genvar j = 0; j < DATA_WIDTH; j++) begin : g_fa
        assign w_s[j]       = w_a[j] ^ w_b[j] ^ w_carry[j];
        assign w_carry[j+1] = (w_a[j] & w_b[j]) | (w_carry[j] & (w_a[j] ^ w_b[j]));
    end
    assign w_can     = !r_valid || res_ready;
    assign req_ready = (w_found && w_can && !reset) ? (NUM_REQ'(1) << w_win) : '0;
    assign w_xfer    = |req_ready;
    assign res_valid = r_valid;
    assign res_sum   = r_sum;
    assign res_id    = r_id;
    // result register and priority pointer; a transfer overwrites even when draining the same cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_sum   <= '0;
            r_id    <= '0;
            r_prio  <= '0;
        end else if (w_xfer) begin
            r_valid <= 1'b1;
            r_sum   <= {w_carry[DATA_WIDTH], w_s};
            r_id    <= w_win;
            r_prio  <= (w_win == ID_W'(NUM_REQ-1)) ? '0 : w_win + 1'b1;
        end else if (res_ready) begin
            r_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_shared_adder_arbiter.sv
// tb_shared_adder_arbiter: directed and randomized checks against a behavioural round-robin/adder model
module tb_shared_adder_arbiter;
    localparam int DW = 8;
    localparam int N  = 4;
    localparam int IW = 2;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [N-1:0]    req_valid = '0;
    logic [N*DW-1:0] req_a = '0;
    logic [N*DW-1:0] req_b = '0;
    logic [N-1:0]    req_ready;
    logic            res_valid;
    logic            res_ready = 1'b0;
    logic [DW:0]     res_sum;
    logic [IW-1:0]   res_id;

    int n_checks = 0;
    int n_pass   = 0;

    bit          m_valid;
    logic [DW:0] m_sum;
    int          m_id;
    int          m_prio;

    shared_adder_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(N)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
        .req_ready(req_ready), .res_valid(res_valid), .res_ready(res_ready),
        .res_sum(res_sum), .res_id(res_id)
    );

    always #5 clk = ~clk;

    function automatic int model_winner();
        for (int k = 0; k < N; k++)
            if (req_valid[(m_prio + k) % N]) return (m_prio + k) % N;
        return -1;
    endfunction

    function automatic logic [N-1:0] model_ready();
        int w = model_winner();
        if (reset || w < 0 || !(!m_valid || res_ready)) return '0;
        return N'(1) << w;
    endfunction

    task automatic model_reset();
        m_valid = 1'b0;
        m_sum   = '0;
        m_id    = 0;
        m_prio  = 0;
    endtask

    task automatic tick();
        int w;
        bit can;
        w   = model_winner();
        can = !m_valid || res_ready;
        @(posedge clk);
        if (w >= 0 && can && !reset) begin
            m_sum   = {1'b0, req_a[w*DW +: DW]} + {1'b0, req_b[w*DW +: DW]};
            m_id    = w;
            m_valid = 1'b1;
            m_prio  = (w + 1) % N;
        end else if (res_ready && !reset) begin
            m_valid = 1'b0;
        end
        #1;
    endtask

    task automatic randomize_inputs();
        req_valid = N'($urandom);
        req_a     = $urandom;
        req_b     = $urandom;
        res_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic test_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        n_checks++;
        if (res_valid !== 1'b0 || res_sum !== '0 || res_id !== '0 || req_ready !== '0)
            $display("FAIL reset_init: got v=%0b sum=%h id=%0d rdy=%b want 0/000/0/0000", res_valid, res_sum, res_id, req_ready);
        else n_pass++;
        reset = 1'b0;
        model_reset();
        for (int c = 0; c < 6; c++) begin
            randomize_inputs();
            tick();
        end
        req_valid = 4'b1111;
        res_ready = 1'b0;
        tick();
        reset = 1'b1;
        #1;
        n_checks++;
        if (res_valid !== 1'b0 || res_sum !== '0 || res_id !== '0 || req_ready !== '0)
            $display("FAIL reset_async: got v=%0b sum=%h id=%0d rdy=%b want 0/000/0/0000", res_valid, res_sum, res_id, req_ready);
        else n_pass++;
        model_reset();
        @(posedge clk);
        #1;
        reset     = 1'b0;
        req_valid = 4'b0100;
        res_ready = 1'b1;
        #1;
        n_checks++;
        if (req_ready !== 4'b0100) $display("FAIL reset_grant: got rdy=%b want 0100", req_ready);
        else n_pass++;
        tick();
        n_checks++;
        if (res_valid !== 1'b1 || res_id !== 2'd2) $display("FAIL reset_result: got v=%0b id=%0d want 1/2", res_valid, res_id);
        else n_pass++;
    endtask

    task automatic test_single();
        req_valid = 4'b0001;
        req_a[7:0] = 8'hFF;
        req_b[7:0] = 8'h01;
        res_ready = 1'b1;
        #1;
        n_checks++;
        if (req_ready !== 4'b0001) $display("FAIL single_ready: got %b want 0001", req_ready);
        else n_pass++;
        tick();
        n_checks++;
        if (res_valid !== 1'b1 || res_sum !== 9'h100 || res_id !== 2'd0)
            $display("FAIL single_result: got v=%0b sum=%h id=%0d want 1/100/0", res_valid, res_sum, res_id);
        else n_pass++;
        req_valid = '0;
    endtask

    task automatic test_round_robin();
        reset = 1'b1;
        #1;
        model_reset();
        @(posedge clk);
        #1;
        reset     = 1'b0;
        req_valid = 4'b1111;
        res_ready = 1'b1;
        req_a     = {8'd3, 8'd2, 8'd1, 8'd0};
        req_b     = {4{8'h10}};
        for (int k = 0; k < 8; k++) begin
            #1;
            n_checks++;
            if (req_ready !== 4'(1 << (k % 4))) $display("FAIL rr_ready[%0d]: got %b want %b", k, req_ready, 4'(1 << (k % 4)));
            else n_pass++;
            tick();
            n_checks++;
            if (res_valid !== 1'b1 || res_id !== IW'(k % 4) || res_sum !== 9'(9'h010 + k % 4))
                $display("FAIL rr_result[%0d]: got v=%0b id=%0d sum=%h want 1/%0d/%h", k, res_valid, res_id, res_sum, k % 4, 9'(9'h010 + k % 4));
            else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        req_valid  = 4'b0001;
        req_a[7:0] = 8'hFF;
        req_b[7:0] = 8'hFF;
        res_ready  = 1'b1;
        tick();
        req_valid = 4'b1111;
        res_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            req_a = $urandom;
            req_b = $urandom;
            #1;
            n_checks++;
            if (req_ready !== '0) $display("FAIL bp_ready[%0d]: got %b want 0000", c, req_ready);
            else n_pass++;
            tick();
            n_checks++;
            if (res_valid !== 1'b1 || res_sum !== 9'h1FE || res_id !== 2'd0)
                $display("FAIL bp_hold[%0d]: got v=%0b sum=%h id=%0d want 1/1fe/0", c, res_valid, res_sum, res_id);
            else n_pass++;
        end
        req_valid   = 4'b0010;
        req_a[15:8] = 8'h80;
        req_b[15:8] = 8'h81;
        res_ready   = 1'b1;
        #1;
        n_checks++;
        if (req_ready !== 4'b0010) $display("FAIL bp_release_ready: got %b want 0010", req_ready);
        else n_pass++;
        tick();
        n_checks++;
        if (res_valid !== 1'b1 || res_sum !== 9'h101 || res_id !== 2'd1)
            $display("FAIL bp_release_result: got v=%0b sum=%h id=%0d want 1/101/1", res_valid, res_sum, res_id);
        else n_pass++;
    endtask

    task automatic test_drain();
        req_valid = '0;
        res_ready = 1'b1;
        tick();
        n_checks++;
        if (res_valid !== 1'b0 || res_sum !== 9'h101 || res_id !== 2'd1)
            $display("FAIL drain_empty: got v=%0b sum=%h id=%0d want 0/101/1", res_valid, res_sum, res_id);
        else n_pass++;
        tick();
        req_valid = 4'b1111;
        #1;
        n_checks++;
        if (req_ready !== 4'b0100) $display("FAIL drain_prio: got %b want 0100", req_ready);
        else n_pass++;
        tick();
        n_checks++;
        if (res_valid !== 1'b1 || res_id !== 2'd2) $display("FAIL drain_grant: got v=%0b id=%0d want 1/2", res_valid, res_id);
        else n_pass++;
    endtask

    task automatic test_fairness();
        for (int r = 0; r < 6; r++) begin
            int  others;
            bit  granted;
            req_valid = {1'b0, 3'($urandom)};
            res_ready = 1'b1;
            for (int c = 0; c < int'($urandom_range(0, 3)); c++) tick();
            others  = 0;
            granted = 1'b0;
            for (int c = 0; c < 20 && !granted; c++) begin
                req_valid = {1'b1, 3'($urandom)};
                req_a     = $urandom;
                req_b     = $urandom;
                res_ready = 1'($urandom_range(0, 3) != 0);
                #1;
                n_checks++;
                if (req_ready !== model_ready()) $display("FAIL fair_ready[%0d.%0d]: got %b want %b", r, c, req_ready, model_ready());
                else n_pass++;
                if (req_ready[3]) granted = 1'b1;
                else if (|req_ready) others++;
                tick();
            end
            n_checks++;
            if (!granted || others > 3) $display("FAIL fair_bound[%0d]: got granted=%0b others=%0d want 1 and <=3", r, granted, others);
            else n_pass++;
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            randomize_inputs();
            #1;
            n_checks++;
            if (req_ready !== model_ready()) $display("FAIL rand_ready[%0d]: got %b want %b", c, req_ready, model_ready());
            else n_pass++;
            tick();
            n_checks++;
            if (res_valid !== m_valid || res_sum !== m_sum || res_id !== IW'(m_id))
                $display("FAIL rand_out[%0d]: got v=%0b sum=%h id=%0d want v=%0b sum=%h id=%0d", c, res_valid, res_sum, res_id, m_valid, m_sum, m_id);
            else n_pass++;
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single();
        test_round_robin();
        test_back_to_back();
        test_drain();
        test_fairness();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
